mux_bus_arbiter: RTL

- Sequencer and arbiter for the shared 20-bit 2:1 select datapath.
- Two requesters (A, B) compete for one 20-bit output channel.
- The block decides ownership with round-robin priority and a bounded burst length.
- It drives the select line, performs a per-word grant handshake, and registers the winning word into a valid/ready output stage.
- It sits between the two producer stages and the single downstream consumer.

---
 rtl/mux_bus_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mux_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mux_bus_arbiter
//   Sequencer and arbiter for a shared 2:1 select datapath. Two requesters
//   (A, B) compete for one output channel. Ownership is decided round-robin
//   with a bounded burst length. The winning word is registered into a
//   valid/ready output stage.
//
//   Handshakes:
//     - Requesters hold req_x and data_x until gnt_x is seen high. The word is
//       transferred on any rising edge where gnt_x is high.
//     - Output stage: out_data is transferred on any rising edge where
//       out_valid and out_ready are both high.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req_a     in   requester A has a word on data_a
//   data_a    in   requester A word
//   gnt_a     out  A's word is accepted this cycle
//   req_b     in   requester B has a word on data_b
//   data_b    in   requester B word
//   gnt_b     out  B's word is accepted this cycle
//   sel       out  mux select (0 = A, 1 = B)
//   out_data  out  registered output word
//   out_valid out  out_data holds an unconsumed word
//   out_ready in   consumer accepts out_data this cycle
//   busy      out  an owner currently holds the bus
// -----------------------------------------------------------------------------
module mux_bus_arbiter #(
   parameter int WIDTH     = 20,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   output logic             gnt_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

   state_t             state_q, state_d;
   logic               last_b_q, last_b_d;   // 1 = B owned the bus most recently
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;

   logic own_a, own_b, load_en, gnt_any, req_own, req_oth, burst_end;

   assign own_a   = (state_q == OWN_A);
   assign own_b   = (state_q == OWN_B);
   // The output register can take a new word when empty or being drained.
   assign load_en = !out_valid_q || out_ready;
   assign gnt_a   = own_a && req_a && load_en;
   assign gnt_b   = own_b && req_b && load_en;
   assign gnt_any = gnt_a || gnt_b;
   assign req_own = own_b ? req_b : req_a;
   assign req_oth = own_b ? req_a : req_b;
   // Grant of the last word the owner may move in one burst.
   assign burst_end = gnt_any && (cnt_q == LAST_CNT);

   always_comb begin
      state_d     = state_q;
      last_b_d    = last_b_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (gnt_any) begin
         out_data_d  = own_b ? data_b : data_a;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // On a tie the requester that did not own the bus last wins.
            if (req_a && (!req_b || last_b_q)) begin
               state_d  = OWN_A;
               last_b_d = 1'b0;
               cnt_d    = '0;
            end else if (req_b) begin
               state_d  = OWN_B;
               last_b_d = 1'b1;
               cnt_d    = '0;
            end
         end
         OWN_A, OWN_B: begin
            if (!req_own || (burst_end && req_oth)) begin
               if (req_oth) begin
                  // Direct handover: no idle cycle between owners.
                  state_d  = own_b ? OWN_A : OWN_B;
                  last_b_d = own_a;
                  cnt_d    = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (gnt_any) begin
               // With no contender the owner keeps the bus; the count wraps.
               cnt_d = burst_end ? '0 : cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_b_q    <= 1'b1;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_b_q    <= last_b_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sel       = own_b;
   assign busy      = own_a || own_b;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule
